// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_rx
//  Purpose  : PS/2 device-to-host receiver with clock glitch filter, odd-parity
//             and stop-bit checking, and inter-edge timeout.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2c,
   input  logic       ps2d,
   input  logic       rx_en,
   output logic [7:0] scan_code,
   output logic       scan_done_tick,
   output logic       parity_err,
   output logic       frame_err
);

   localparam int                c_TW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_TW-1:0]   c_TMAX = c_TW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]        c_NBITS = 4'd10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      LOAD = 2'd2
   } state_t;

   state_t                r_state, w_state_next;
   logic [1:0]            r_c_sync, r_d_sync;
   logic [FILTER_LEN-1:0] r_hist;
   logic                  r_filt, r_filt_d;
   logic                  w_fall;
   logic [3:0]            r_n, w_n_next;
   logic [9:0]            r_b, w_b_next, w_b_shift;
   logic [c_TW-1:0]       r_t, w_t_next;
   logic [7:0]            r_code, w_code_next;
   logic                  r_perr, w_perr_next;
   logic                  r_ferr, w_ferr_next;

   // Pin synchronizers and clock filter; the filtered level only moves once
   // the whole sample history agrees.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_c_sync <= 2'b11;
         r_d_sync <= 2'b11;
         r_hist   <= '1;
         r_filt   <= 1'b1;
         r_filt_d <= 1'b1;
      end else begin
         r_c_sync <= {r_c_sync[0], ps2c};
         r_d_sync <= {r_d_sync[0], ps2d};
         r_hist   <= {r_hist[FILTER_LEN-2:0], r_c_sync[1]};
         if (&r_hist)
            r_filt <= 1'b1;
         else if (~|r_hist)
            r_filt <= 1'b0;
         r_filt_d <= r_filt;
      end
   end

   assign w_fall    = r_filt_d & ~r_filt;
   assign w_b_shift = {r_d_sync[1], r_b[9:1]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_n     <= '0;
         r_b     <= '0;
         r_t     <= '0;
         r_code  <= 8'h00;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_n     <= w_n_next;
         r_b     <= w_b_next;
         r_t     <= w_t_next;
         r_code  <= w_code_next;
         r_perr  <= w_perr_next;
         r_ferr  <= w_ferr_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_n_next     = r_n;
      w_b_next     = r_b;
      w_t_next     = r_t;
      w_code_next  = r_code;
      w_perr_next  = 1'b0;
      w_ferr_next  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_fall && rx_en && !r_d_sync[1]) begin
               w_state_next = DATA;
               w_n_next     = c_NBITS;
               w_t_next     = '0;
            end
         end
         DATA: begin
            if (w_fall) begin
               w_b_next = w_b_shift;
               w_n_next = r_n - 4'd1;
               w_t_next = '0;
               // Last edge carries the stop bit: judge the assembled frame.
               if (r_n == 4'd1) begin
                  if (!w_b_shift[9]) begin
                     w_ferr_next  = 1'b1;
                     w_state_next = IDLE;
                  end else if (^w_b_shift[8:0]) begin
                     w_code_next  = w_b_shift[7:0];
                     w_state_next = LOAD;
                  end else begin
                     w_perr_next  = 1'b1;
                     w_state_next = IDLE;
                  end
               end
            end else if (r_t == c_TMAX) begin
               w_ferr_next  = 1'b1;
               w_t_next     = '0;
               w_state_next = IDLE;
            end else begin
               w_t_next = r_t + 1'b1;
            end
         end
         LOAD: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign scan_code      = r_code;
   assign scan_done_tick = (r_state == LOAD);
   assign parity_err     = r_perr;
   assign frame_err      = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_rx
//  Purpose  : Directed self-checking bench for ps2_rx.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_rx;

   localparam int c_TIMEOUT = 2000;
   localparam int c_H       = 100;

   logic       clk;
   logic       reset;
   logic       ps2c;
   logic       ps2d;
   logic       rx_en;
   logic [7:0] scan_code;
   logic       scan_done_tick;
   logic       parity_err;
   logic       frame_err;

   int n_cmp  = 0;
   int n_fail = 0;
   int n_tick = 0;
   int n_perr = 0;
   int n_ferr = 0;
   int n_ovl  = 0;
   logic [7:0] codes[$];

   ps2_rx #(
      .FILTER_LEN     (8),
      .TIMEOUT_CYCLES (c_TIMEOUT)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .ps2c           (ps2c),
      .ps2d           (ps2d),
      .rx_en          (rx_en),
      .scan_code      (scan_code),
      .scan_done_tick (scan_done_tick),
      .parity_err     (parity_err),
      .frame_err      (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset) begin
         if (scan_done_tick) begin
            n_tick <= n_tick + 1;
            codes.push_back(scan_code);
         end
         if (parity_err) n_perr <= n_perr + 1;
         if (frame_err)  n_ferr <= n_ferr + 1;
         if (int'(scan_done_tick) + int'(parity_err) + int'(frame_err) > 1)
            n_ovl <= n_ovl + 1;
      end
   end

   // Drives nbits of a frame; glitch_bit gets a 3-cycle low pulse mid high
   // phase, drop_bit lowers rx_en after that bit.
   task automatic send_frame(input logic [7:0] data, input logic flip_par,
                             input logic bad_stop, input int nbits,
                             input int glitch_bit, input int drop_bit);
      logic [10:0] fr;
      fr = {~bad_stop, (~^data) ^ flip_par, data, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2d = fr[i];
         repeat (c_H/2) @(posedge clk);
         if (i == glitch_bit) begin
            ps2c = 1'b0;
            repeat (3) @(posedge clk);
            ps2c = 1'b1;
         end
         repeat (c_H/2) @(posedge clk);
         ps2c = 1'b0;
         repeat (c_H) @(posedge clk);
         ps2c = 1'b1;
         if (i == drop_bit) rx_en = 1'b0;
      end
      ps2d = 1'b1;
      repeat (c_H) @(posedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      ps2c  = 1'b1;
      ps2d  = 1'b1;
      rx_en = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      n_cmp++; if (scan_code !== 8'h00) begin n_fail++; $display("FAIL reset_code got=%h exp=00", scan_code); end
      n_cmp++; if (scan_done_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%b exp=0", scan_done_tick); end
      n_cmp++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
      n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
      reset = 1'b1;
      repeat (20) @(posedge clk);
   endtask

   task automatic test_single();
      int t0, p0, f0;
      t0 = n_tick; p0 = n_perr; f0 = n_ferr;
      send_frame(8'h1C, 1'b0, 1'b0, 11, -1, -1);
      n_cmp++; if (n_tick - t0 !== 1) begin n_fail++; $display("FAIL single_ticks got=%0d exp=1", n_tick - t0); end
      n_cmp++; if (scan_code !== 8'h1C) begin n_fail++; $display("FAIL single_code got=%h exp=1c", scan_code); end
      n_cmp++; if (n_perr - p0 + n_ferr - f0 !== 0) begin n_fail++; $display("FAIL single_errs got=%0d exp=0", n_perr - p0 + n_ferr - f0); end
   endtask

   task automatic test_back_to_back();
      int t0;
      t0 = n_tick;
      codes.delete();
      send_frame(8'hF0, 1'b0, 1'b0, 11, -1, -1);
      send_frame(8'h1C, 1'b0, 1'b0, 11, -1, -1);
      n_cmp++; if (n_tick - t0 !== 2) begin n_fail++; $display("FAIL b2b_ticks got=%0d exp=2", n_tick - t0); end
      if (codes.size() == 2) begin
         n_cmp++; if (codes[0] !== 8'hF0) begin n_fail++; $display("FAIL b2b_first got=%h exp=f0", codes[0]); end
         n_cmp++; if (codes[1] !== 8'h1C) begin n_fail++; $display("FAIL b2b_second got=%h exp=1c", codes[1]); end
      end else begin
         n_cmp++; n_fail++;
         $display("FAIL b2b_codes got=%0d entries exp=2", codes.size());
      end
   endtask

   task automatic test_parity();
      int t0, p0, f0;
      t0 = n_tick; p0 = n_perr; f0 = n_ferr;
      send_frame(8'h1C, 1'b1, 1'b0, 11, -1, -1);
      n_cmp++; if (n_perr - p0 !== 1) begin n_fail++; $display("FAIL parity_perr got=%0d exp=1", n_perr - p0); end
      n_cmp++; if (n_tick - t0 !== 0) begin n_fail++; $display("FAIL parity_ticks got=%0d exp=0", n_tick - t0); end
      n_cmp++; if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL parity_ferr got=%0d exp=0", n_ferr - f0); end
      n_cmp++; if (scan_code !== 8'h1C) begin n_fail++; $display("FAIL parity_code got=%h exp=1c", scan_code); end
   endtask

   task automatic test_stop_bit();
      int t0, p0, f0;
      t0 = n_tick; p0 = n_perr; f0 = n_ferr;
      send_frame(8'hF0, 1'b1, 1'b1, 11, -1, -1);
      n_cmp++; if (n_ferr - f0 !== 1) begin n_fail++; $display("FAIL stop_ferr got=%0d exp=1", n_ferr - f0); end
      n_cmp++; if (n_perr - p0 !== 0) begin n_fail++; $display("FAIL stop_perr got=%0d exp=0", n_perr - p0); end
      n_cmp++; if (n_tick - t0 !== 0) begin n_fail++; $display("FAIL stop_ticks got=%0d exp=0", n_tick - t0); end
      n_cmp++; if (scan_code !== 8'h1C) begin n_fail++; $display("FAIL stop_code got=%h exp=1c", scan_code); end
   endtask

   task automatic test_glitch();
      int t0, e0;
      t0 = n_tick; e0 = n_perr + n_ferr;
      ps2d = 1'b0;
      repeat (10) @(posedge clk);
      ps2c = 1'b0;
      repeat (3) @(posedge clk);
      ps2c = 1'b1;
      repeat (40) @(posedge clk);
      ps2d = 1'b1;
      repeat (c_H) @(posedge clk);
      send_frame(8'h1C, 1'b0, 1'b0, 11, 4, -1);
      n_cmp++; if (n_tick - t0 !== 1) begin n_fail++; $display("FAIL glitch_ticks got=%0d exp=1", n_tick - t0); end
      n_cmp++; if (scan_code !== 8'h1C) begin n_fail++; $display("FAIL glitch_code got=%h exp=1c", scan_code); end
      n_cmp++; if (n_perr + n_ferr - e0 !== 0) begin n_fail++; $display("FAIL glitch_errs got=%0d exp=0", n_perr + n_ferr - e0); end
   endtask

   task automatic test_rx_en();
      int t0;
      t0 = n_tick;
      rx_en = 1'b0;
      send_frame(8'hF0, 1'b0, 1'b0, 11, -1, -1);
      n_cmp++; if (n_tick - t0 !== 0) begin n_fail++; $display("FAIL rxen_off_ticks got=%0d exp=0", n_tick - t0); end
      n_cmp++; if (scan_code !== 8'h1C) begin n_fail++; $display("FAIL rxen_off_code got=%h exp=1c", scan_code); end
      rx_en = 1'b1;
      t0 = n_tick;
      send_frame(8'hF0, 1'b0, 1'b0, 11, -1, 2);
      n_cmp++; if (n_tick - t0 !== 1) begin n_fail++; $display("FAIL rxen_drop_ticks got=%0d exp=1", n_tick - t0); end
      n_cmp++; if (scan_code !== 8'hF0) begin n_fail++; $display("FAIL rxen_drop_code got=%h exp=f0", scan_code); end
      rx_en = 1'b1;
   endtask

   task automatic test_timeout();
      int t0, f0;
      t0 = n_tick; f0 = n_ferr;
      send_frame(8'h1C, 1'b0, 1'b0, 5, -1, -1);
      repeat (c_TIMEOUT + 500) @(posedge clk);
      n_cmp++; if (n_ferr - f0 !== 1) begin n_fail++; $display("FAIL timeout_ferr got=%0d exp=1", n_ferr - f0); end
      n_cmp++; if (n_tick - t0 !== 0) begin n_fail++; $display("FAIL timeout_ticks got=%0d exp=0", n_tick - t0); end
      t0 = n_tick;
      send_frame(8'h1C, 1'b0, 1'b0, 11, -1, -1);
      n_cmp++; if (n_tick - t0 !== 1) begin n_fail++; $display("FAIL timeout_next_ticks got=%0d exp=1", n_tick - t0); end
      n_cmp++; if (scan_code !== 8'h1C) begin n_fail++; $display("FAIL timeout_next_code got=%h exp=1c", scan_code); end
   endtask

   task automatic test_mid_reset();
      int t0;
      t0 = n_tick;
      send_frame(8'h1C, 1'b0, 1'b0, 4, -1, -1);
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      n_cmp++; if (scan_code !== 8'h00) begin n_fail++; $display("FAIL midrst_code got=%h exp=00", scan_code); end
      reset = 1'b1;
      repeat (3 * c_H) @(posedge clk);
      n_cmp++; if (n_tick - t0 !== 0) begin n_fail++; $display("FAIL midrst_ticks got=%0d exp=0", n_tick - t0); end
      send_frame(8'h1C, 1'b0, 1'b0, 11, -1, -1);
      n_cmp++; if (n_tick - t0 !== 1) begin n_fail++; $display("FAIL midrst_next_ticks got=%0d exp=1", n_tick - t0); end
      n_cmp++; if (scan_code !== 8'h1C) begin n_fail++; $display("FAIL midrst_next_code got=%h exp=1c", scan_code); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_parity();
      test_stop_bit();
      test_glitch();
      test_rx_en();
      test_timeout();
      test_mid_reset();
      n_cmp++; if (n_ovl !== 0) begin n_fail++; $display("FAIL pulse_overlap got=%0d exp=0", n_ovl); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
